pc_sequencer: RTL

//  Owns the program counter and sequences the RV32I core: fetch, execute, PC update.

---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// RV32I program-counter sequencer: fetch / execute / PC update with next-PC selection.
// Optional MISALIGN_TRAP_EN: misaligned control-flow targets divert to TRAP_VEC instead of retiring.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   input  logic        stall,
   input  logic        is_branch,
   input  logic        br_taken,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [31:0] sb_target,
   input  logic [31:0] uj_target,
   input  logic [31:0] jalr_base,
   output logic        retire,
   output logic        trap,
   output logic [31:0] trap_pc
);

   // state   | meaning
   // S_IDLE  | one cycle after reset before the first fetch
   // S_FETCH | imem request outstanding, waiting for imem_ready
   // S_EXEC  | instruction held for the datapath, retires when stall is low
   // S_TRAP  | misaligned target reported, pc already at TRAP_VEC (macro only)
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
`ifdef MISALIGN_TRAP_EN
      , S_TRAP = 2'd3
`endif
   } state_t;

   if ((RESET_PC[1:0] != 2'b00) || (TRAP_VEC[1:0] != 2'b00)) begin : g_bad_vec
      $error("pc_sequencer: RESET_PC and TRAP_VEC must be word aligned");
   end

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_plus4;
   logic [31:0] tgt;
   logic        use_tgt;
   logic [31:0] next_pc;
   logic        misalign;
   logic [31:0] pc_nxt;
   logic        pc_load;
   logic        instr_load;

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      tgt     = pc_plus4;
      use_tgt = 1'b0;
      if (is_jalr) begin
         tgt     = {jalr_base[31:1], 1'b0};
         use_tgt = 1'b1;
      end else if (is_jal) begin
         tgt     = uj_target;
         use_tgt = 1'b1;
      end else if (is_branch && br_taken) begin
         tgt     = sb_target;
         use_tgt = 1'b1;
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic trap_load;

   assign misalign = use_tgt & tgt[1];
   assign next_pc  = tgt;
   assign trap     = (state == S_TRAP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trap_pc <= '0;
      end else if (trap_load) begin
         trap_pc <= pc;
      end
   end
`else
   // Without the trap, low target bits are simply dropped so the PC stays word aligned.
   assign misalign = 1'b0;
   assign next_pc  = use_tgt ? {tgt[31:2], 2'b00} : pc_plus4;
   assign trap     = 1'b0;
   assign trap_pc  = '0;
`endif

   always_comb begin
      state_nxt  = state;
      pc_nxt     = next_pc;
      pc_load    = 1'b0;
      instr_load = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_load  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ready) begin
               instr_load = 1'b1;
               state_nxt  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               pc_load   = 1'b1;
               state_nxt = S_FETCH;
`ifdef MISALIGN_TRAP_EN
               if (misalign) begin
                  pc_nxt    = TRAP_VEC;
                  trap_load = 1'b1;
                  state_nxt = S_TRAP;
               end
`endif
            end
         end
`ifdef MISALIGN_TRAP_EN
         S_TRAP: begin
            state_nxt = S_FETCH;
         end
`endif
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         state <= state_nxt;
         if (pc_load) begin
            pc <= pc_nxt;
         end
         if (instr_load) begin
            instr <= imem_rdata;
         end
      end
   end

   assign imem_req    = (state == S_FETCH);
   assign imem_addr   = imem_req ? pc : '0;
   assign instr_valid = (state == S_EXEC);
   assign link_addr   = pc_plus4;
   assign retire      = (state == S_EXEC) && !stall && !misalign;

endmodule
